// File: rtl/note_lane_scroller.sv
// note_lane_scroller
// Falling-note lane engine for the rhythm game. It holds LANES shift registers
// of DEPTH cells each and advances them one cell per game tick. The early tick
// pulse opens a hit window, and key presses are judged against the bottom
// (hit-zone) cell of each lane. The block also keeps the score and lives and
// runs the IDLE/PLAY/OVER game state machine.
//
// Optional feature macro: NOTE_LANE_MISPRESS_PENALTY_EN
//   When defined, every press that does not score a hit takes 1 off the score
//   (saturating at 0). Hits and penalties in the same cycle are netted first.
//
// Ports
//   CLOCK_50    system clock, posedge
//   RESETN      asynchronous active-low reset
//   tick        one-cycle game tick (shift, miss judgement)
//   tick_early  one-cycle pulse ahead of tick, arms the hit window
//   start       level, starts a game from IDLE or OVER
//   note_in     new note per lane, loaded into cell 0 on tick
//   key         player buttons, active-high, already synchronised
//   lane_bits   lane L cell i at bit L*DEPTH+i (cell DEPTH-1 = hit zone)
//   score       current score, saturating
//   lives       lives remaining
//   playing     high in PLAY
//   game_over   high in OVER
//   hit_pulse   one-cycle strobe per lane on a judged hit
//   miss_pulse  one-cycle strobe per lane on a miss
//
// State | Meaning
// ------+------------------------------------------------------------
// IDLE  | after reset; waits for start, ticks and keys ignored
// PLAY  | lanes scroll, hits and misses judged, score/lives updated
// OVER  | lives exhausted; lanes, score and lives frozen until start

module note_lane_scroller #(
    parameter int LANES   = 4,
    parameter int DEPTH   = 16,
    parameter int SCORE_W = 16,
    parameter int LIVES   = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     RESETN,
    input  logic                     tick,
    input  logic                     tick_early,
    input  logic                     start,
    input  logic [LANES-1:0]         note_in,
    input  logic [LANES-1:0]         key,
    output logic [LANES*DEPTH-1:0]   lane_bits,
    output logic [SCORE_W-1:0]       score,
    output logic [3:0]               lives,
    output logic                     playing,
    output logic                     game_over,
    output logic [LANES-1:0]         hit_pulse,
    output logic [LANES-1:0]         miss_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_OVER
    } state_t;

    // Extra headroom so hit additions and penalty subtractions can be netted
    // before saturating at either end.
    localparam int SW = SCORE_W + 5;

    state_t                  state;
    logic                    armed;
    logic [LANES-1:0]        key_q;
    logic [LANES-1:0]        press;
    logic [LANES-1:0]        hit_cells;
    logic [LANES-1:0]        hit_vec;
    logic [LANES-1:0]        miss_vec;
    logic [LANES*DEPTH-1:0]  lanes_hit;
    logic [LANES*DEPTH-1:0]  lanes_shift;
    logic [3:0]              hit_cnt;
    logic [3:0]              miss_cnt;
    logic [SW-1:0]           score_up;
    logic [SW-1:0]           score_net;
    logic [SCORE_W-1:0]      score_next;
    logic [3:0]              lives_next;
`ifdef NOTE_LANE_MISPRESS_PENALTY_EN
    logic [3:0]              stray_cnt;
`endif

    function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        press     = key & ~key_q;
        hit_cells = '0;
        for (int l = 0; l < LANES; l++) begin
            hit_cells[l] = lane_bits[l*DEPTH + DEPTH - 1];
        end
        hit_vec  = armed ? (press & hit_cells) : '0;
        // Miss judgement sees the hit-zone contents after this cycle's hits.
        miss_vec = tick ? (hit_cells & ~hit_vec) : '0;

        lanes_hit = lane_bits;
        for (int l = 0; l < LANES; l++) begin
            if (hit_vec[l]) begin
                lanes_hit[l*DEPTH + DEPTH - 1] = 1'b0;
            end
        end

        // Shift toward the hit zone; the old hit-zone cell falls off the end.
        lanes_shift = '0;
        for (int l = 0; l < LANES; l++) begin
            lanes_shift[l*DEPTH +: DEPTH] = {lanes_hit[l*DEPTH +: DEPTH-1], note_in[l]};
        end

        hit_cnt  = popcount(hit_vec);
        miss_cnt = popcount(miss_vec);

        score_up = SW'(score) + SW'(hit_cnt);
`ifdef NOTE_LANE_MISPRESS_PENALTY_EN
        stray_cnt = popcount(press & ~hit_vec);
        if (score_up < SW'(stray_cnt)) begin
            score_net = '0;
        end else begin
            score_net = score_up - SW'(stray_cnt);
        end
`else
        score_net = score_up;
`endif
        if (score_net > SW'({SCORE_W{1'b1}})) begin
            score_next = '1;
        end else begin
            score_next = score_net[SCORE_W-1:0];
        end

        lives_next = (lives > miss_cnt) ? (lives - miss_cnt) : 4'd0;
    end

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            state      <= S_IDLE;
            lane_bits  <= '0;
            score      <= '0;
            lives      <= '0;
            armed      <= 1'b0;
            key_q      <= '0;
            hit_pulse  <= '0;
            miss_pulse <= '0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            key_q      <= key;
            hit_pulse  <= '0;
            miss_pulse <= '0;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state     <= S_PLAY;
                        lane_bits <= '0;
                        score     <= '0;
                        lives     <= 4'(LIVES);
                        armed     <= 1'b0;
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                S_PLAY: begin
                    hit_pulse <= hit_vec;
                    score     <= score_next;
                    if (tick) begin
                        lane_bits  <= lanes_shift;
                        miss_pulse <= miss_vec;
                        lives      <= lives_next;
                        armed      <= 1'b0;   // tick wins over a coincident tick_early
                        if (lives_next == 4'd0) begin
                            state     <= S_OVER;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                        end
                    end else begin
                        lane_bits <= lanes_hit;
                        if (tick_early) begin
                            armed <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    playing   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/note_lane_scroller.md
Name: note_lane_scroller

Overview:
- Consumer of the game clock's tick pulses (NEW_PULSE / NEW_PULSE_EARLY) in the rhythm-game datapath.
- Holds LANES falling-note shift registers and advances them one cell per game tick.
- Opens a hit window on the early pulse and judges player key presses against the bottom (hit-zone) cell.
- Maintains score and lives, and runs the IDLE/PLAY/OVER game state machine that feeds the display and HUD logic.

Parameters:
- LANES, 4, number of note lanes (1..8).
- DEPTH, 16, cells per lane; index 0 is the top, index DEPTH-1 is the hit zone.
- SCORE_W, 16, score counter width.
- LIVES, 3, lives loaded at game start (1..15).

Ports:
- CLOCK_50 input 1: system clock; all logic on posedge.
- RESETN input 1: asynchronous active-low reset.
- tick input 1: one-cycle game tick pulse (from NEW_PULSE).
- tick_early input 1: one-cycle pulse preceding tick (from NEW_PULSE_EARLY); opens the hit window.
- start input 1: level; sampled in IDLE and OVER.
- note_in input LANES: new note per lane, sampled on tick.
- key input LANES: player buttons, active-high, already synchronised to CLOCK_50.
- lane_bits output LANES*DEPTH: lane L cell i at bit L*DEPTH+i.
- score output SCORE_W: current score.
- lives output 4: lives remaining.
- playing output 1: high in PLAY.
- game_over output 1: high in OVER.
- hit_pulse output LANES: one-cycle strobe per lane on a judged hit.
- miss_pulse output LANES: one-cycle strobe per lane on a miss.

Behaviour:
- Reset (RESETN low, asynchronous):
  - state=IDLE; lane_bits=0; score=0; lives=0; armed=0.
  - key_q=0; hit_pulse=0; miss_pulse=0.
  - Reset asserted mid-game aborts immediately to these values.
- Key edge detection:
  - key_q registers key every cycle.
  - press[L] = key[L] & ~key_q[L].
- IDLE:
  - playing=0, game_over=0; tick and keys ignored.
  - start=1 -> next cycle PLAY with lane_bits=0, score=0, lives=LIVES, armed=0.
- PLAY, window control:
  - tick_early sets armed=1.
  - tick clears armed=0; applies on the same cycle, after the hit evaluation below.
- PLAY, hit evaluation (every cycle, per lane, uses pre-shift contents):
  - Hit when armed=1, press[L]=1 and cell[L][DEPTH-1]=1.
  - On a hit: clear that cell, score+1 (saturating at all-ones), hit_pulse[L]=1 next cycle.
  - Multiple lanes hitting in one cycle add the number of hits, saturating.
  - A press with armed=0 or an empty hit cell is ignored, unless the optional feature is compiled in.
- PLAY, on tick:
  - Miss: any lane whose hit cell is still 1 after hit evaluation is a miss; miss_pulse[L]=1.
  - lives decreases by the miss count, saturating at 0.
  - Shift: every lane moves one cell down; cell[i+1]<=cell[i]; cell[0]<=note_in[L]; the hit-zone cell is discarded.
- Simultaneous events:
  - tick_early and tick on the same cycle: tick wins; armed ends the cycle 0.
  - A press on the tick cycle is still a valid hit because evaluation precedes the shift.
- PLAY -> OVER when lives reaches 0 after a tick update; the transition is visible the following cycle.
  - In OVER, lane_bits, score and lives freeze.
  - playing=0, game_over=1.
- OVER + start=1 -> PLAY with the same initialisation as from IDLE. start held high in PLAY has no effect.
- Latency:
  - Hit/miss strobes and counters update one cycle after the causing event.
  - lane_bits reflects a tick one cycle after tick.

Optional Feature:
- Macro: NOTE_LANE_MISPRESS_PENALTY_EN.
- Defined: a press that does not qualify as a hit (armed=0 or empty hit cell) subtracts 1 from score, saturating at 0. Penalties and hits in the same cycle are netted, then saturated.
- Undefined: non-qualifying presses have no effect; no penalty logic is synthesised.

Test Plan:
- Reset, then start=1 for 1 cycle -> playing=1, lives=3, score=0, lane_bits=0.
- note_in=4'b0001 on one tick, then 0 for 15 ticks -> lane 0 bit walks 0..15. Next tick with no press -> miss_pulse=4'b0001, lives=2, lane 0 empty.
- Note in lane 2 at cell 15, then tick_early, press key[2] 10 cycles later -> hit_pulse=4'b0100, score=1, cell cleared, no miss at the following tick.
- Note at hit cell, key[1] pressed on the same cycle as tick, with armed=1 -> counted as a hit, not a miss. A press with no preceding tick_early -> no hit; note missed at tick.
- Three notes reach the hit zone with no presses, LIVES=3 -> after that tick lives=0, game_over=1. Further ticks leave lane_bits frozen. start=1 -> PLAY with lives=3, score=0.
- Score preloaded near all-ones (SCORE_W=4, score=15), then a hit -> score stays 15.
- With NOTE_LANE_MISPRESS_PENALTY_EN, a stray press at score=2 -> score=1. A stray press at score=0 -> score stays 0.
